daq_frame_buffer: RTL and testbench
===================================

// Module: daq_frame_buffer
// PURPOSE
//  Store-and-forward buffer directly downstream of the DAQ frame builder. Captures CRC-protected
//  19-bit DAQ words (daqp), stores whole frames in block RAM and replays them to the DMB link
//  with a valid/ready handshake. Admits a frame only if room for a worst-case frame exists;
//  otherwise drops the whole frame and counts it. No partial frame is ever emitted.
// PARAMETERS
//  ADDR_W     12    log2 of buffer depth in words (4096)
//  MAX_FRAME  2048  max words per frame; admission threshold and truncation limit (<= 2**ADDR_W)
// PORTS
//  clk          in   1   system clock
//  hard_rst     in   1   asynchronous active-low reset
//  daqp         in   19  DAQ word stream; bit18=1 idle, bit18=0 data word (payload [17:0])
//  out_data     out  18  frame word payload to DMB
//  out_valid    out  1   out_data/out_last valid
//  out_ready    in   1   DMB accepts word when out_valid && out_ready
//  out_last     out  1   marks last word of frame
//  frames_held  out  8   complete frames stored, not yet fully read
//  fill_words   out  ADDR_W+1  words stored (incl. partial frame being written)
//  drop_count   out  8   frames dropped for lack of space, saturates at 255
//  trunc_count  out  8   frames truncated at MAX_FRAME, saturates at 255
//  overflow     out  1   sticky; set on any drop or truncation, cleared only by reset
// BEHAVIOUR
//  Reset (hard_rst=0, async): pointers 0, all counters 0, out_valid=0, out_last=0, out_data=0,
//   overflow=0, write FSM W_IDLE, read FSM R_IDLE. Reset mid-frame discards everything.
//  Framing: frame = maximal run of consecutive daqp words with bit18=0. End known one cycle
//   late, so input passes through one holding register: each cycle a held word is written with
//   eof=(current daqp[18]==1). Stored entry = {eof, payload[17:0]}. Single-word frame legal.
//  Write FSM:
//   W_IDLE : on daqp[18]==0: free=2**ADDR_W-fill_words; free>=MAX_FRAME -> W_FRAME (hold word,
//            wcnt=1) else W_DROP. Free space evaluated on this cycle only.
//   W_FRAME: write held word each cycle; if wcnt reaches MAX_FRAME while frame continues, that
//            word written with eof=1, trunc_count++, overflow=1 -> W_TRUNC. On eof -> W_IDLE.
//   W_DROP : write nothing; on daqp[18]==1 drop_count++, overflow=1 -> W_IDLE.
//   W_TRUNC: discard words; on daqp[18]==1 -> W_IDLE.
//   Back-to-back frames (one idle cycle between) must be captured with no loss.
//  frames_held: +1 on eof write, -1 on eof read; simultaneous -> unchanged.
//   Saturates at 255 (stall admission: treat as no space -> W_DROP while 255).
//  Read FSM (first-word-fall-through output register):
//   R_IDLE : when frames_held!=0, prefetch first word, out_valid=1 -> R_SEND (2-cycle latency
//            from eof write to out_valid).
//   R_SEND : word held stable while out_ready=0. On transfer with out_last=1 -> R_IDLE if no
//            further frame, else next frame's first word presented next cycle (no bubble
//            required but allowed one). Otherwise next word presented next cycle.
//   out_valid never asserted for a frame whose eof is not yet written.
//  Pointers: ADDR_W bits, wrap modulo 2**ADDR_W; fill_words = writes - reads, full is impossible
//   by admission rule. Simultaneous read and write of different addresses each cycle.
//  Counters drop/trunc saturate (255 stays 255).
// TESTING
//  1) Reset, single 5-word frame (payloads 0x0db0a..0x1d0aa), out_ready=1 -> 5 words out in order,
//     out_last only on 5th, frames_held 0->1->0, fill_words returns to 0.
//  2) Two 3-word frames with one idle cycle between, out_ready=0 -> frames_held=2, fill_words=6;
//     release out_ready -> 6 words, out_last on 3rd and 6th.
//  3) ADDR_W=4, MAX_FRAME=8: hold out_ready=0, send 8-word frame then 4-word frame -> second
//     dropped (free=8<... no, free=8 admitted); third 4-word frame -> dropped, drop_count=1,
//     overflow=1, stored contents unchanged.
//  4) MAX_FRAME=8: send 12-word frame -> 8 words stored, 8th with out_last, trunc_count=1;
//     next normal frame stored intact.
//  5) out_ready toggled every cycle during 10-word frame -> no duplicated/missing words,
//     out_data stable while stalled.
//  6) Assert hard_rst mid-frame in and mid-readout -> outputs 0 immediately; next frame clean.

Source files
------------

// File: rtl/daq_frame_buffer.sv
// Store-and-forward frame buffer: admits whole DAQ frames only when a worst-case frame fits,
// replays complete frames to the DMB link through a first-word-fall-through output register.
module daq_frame_buffer #(
    parameter int ADDR_W    = 12,
    parameter int MAX_FRAME = 2048
) (
    input  logic              clk,
    input  logic              hard_rst,
    input  logic [18:0]       daqp,
    output logic [17:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [7:0]        frames_held,
    output logic [ADDR_W:0]   fill_words,
    output logic [7:0]        drop_count,
    output logic [7:0]        trunc_count,
    output logic              overflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = $clog2(MAX_FRAME + 1);
    localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] MAX_W   = (ADDR_W+1)'(MAX_FRAME);
    localparam logic [CW-1:0]   MAX_C   = CW'(MAX_FRAME);

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_FRAME = 2'd1;
    localparam logic [1:0] W_DROP  = 2'd2;
    localparam logic [1:0] W_TRUNC = 2'd3;
    localparam logic [0:0] R_IDLE  = 1'b0;
    localparam logic [0:0] R_SEND  = 1'b1;

    logic [18:0]       mem [0:DEPTH-1];
    logic [1:0]        wstate_q, wstate_d;
    logic [0:0]        rstate_q, rstate_d;
    logic [17:0]       hold_q, hold_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] wptr_q, rptr_q;
    logic [ADDR_W:0]   fill_q, free;
    logic [7:0]        fh_q, drop_q, trunc_q;
    logic              ovf_q, ovld_q, olast_q;
    logic [17:0]       odat_q;
    logic              in_data, wr_en, wr_eof, drop_inc, trunc_inc;
    logic              xfer, eof_rd, load;
    logic [18:0]       rd_word;

    assign in_data = ~daqp[18];
    assign free    = DEPTH_W - fill_q;

    always_comb begin
        wstate_d  = wstate_q;
        hold_d    = hold_q;
        wcnt_d    = wcnt_q;
        wr_en     = 1'b0;
        wr_eof    = 1'b0;
        drop_inc  = 1'b0;
        trunc_inc = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (in_data) begin
                    // A full frames_held counter blocks admission like a full buffer.
                    if (free >= MAX_W && fh_q != 8'hFF) begin
                        wstate_d = W_FRAME;
                        hold_d   = daqp[17:0];
                        wcnt_d   = CW'(1);
                    end else begin
                        wstate_d = W_DROP;
                    end
                end
            end
            W_FRAME: begin
                wr_en = 1'b1;
                if (!in_data) begin
                    wr_eof   = 1'b1;
                    wstate_d = W_IDLE;
                end else if (wcnt_q == MAX_C) begin
                    wr_eof    = 1'b1;
                    trunc_inc = 1'b1;
                    wstate_d  = W_TRUNC;
                end else begin
                    hold_d = daqp[17:0];
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            W_DROP: begin
                if (!in_data) begin
                    drop_inc = 1'b1;
                    wstate_d = W_IDLE;
                end
            end
            default: begin
                if (!in_data) wstate_d = W_IDLE;
            end
        endcase
    end

    assign xfer    = ovld_q & out_ready;
    assign eof_rd  = xfer & olast_q;
    assign rd_word = mem[rptr_q];

    always_comb begin
        load = 1'b0;
        case (rstate_q)
            R_IDLE:  load = (fh_q != 8'd0);
            default: load = xfer & (~olast_q | (fh_q >= 8'd2));
        endcase
        rstate_d = load ? R_SEND : (xfer ? R_IDLE : rstate_q);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q] <= {wr_eof, hold_q};
    end

    always_ff @(posedge clk or negedge hard_rst) begin
        if (!hard_rst) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
            hold_q   <= '0;
            wcnt_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            fill_q   <= '0;
            fh_q     <= '0;
            drop_q   <= '0;
            trunc_q  <= '0;
            ovf_q    <= 1'b0;
            ovld_q   <= 1'b0;
            olast_q  <= 1'b0;
            odat_q   <= '0;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            hold_q   <= hold_d;
            wcnt_q   <= wcnt_d;
            if (wr_en) wptr_q <= wptr_q + ADDR_W'(1);
            // fill counts the word sitting in the output register until it is accepted
            case ({wr_en, xfer})
                2'b10:   fill_q <= fill_q + (ADDR_W+1)'(1);
                2'b01:   fill_q <= fill_q - (ADDR_W+1)'(1);
                default: fill_q <= fill_q;
            endcase
            case ({wr_en & wr_eof & (fh_q != 8'hFF), eof_rd})
                2'b10:   fh_q <= fh_q + 8'd1;
                2'b01:   fh_q <= fh_q - 8'd1;
                default: fh_q <= fh_q;
            endcase
            if (drop_inc && drop_q != 8'hFF)   drop_q  <= drop_q + 8'd1;
            if (trunc_inc && trunc_q != 8'hFF) trunc_q <= trunc_q + 8'd1;
            if (drop_inc || trunc_inc)         ovf_q   <= 1'b1;
            if (load) begin
                odat_q  <= rd_word[17:0];
                olast_q <= rd_word[18];
                ovld_q  <= 1'b1;
                rptr_q  <= rptr_q + ADDR_W'(1);
            end else if (xfer) begin
                ovld_q  <= 1'b0;
                olast_q <= 1'b0;
            end
        end
    end

    assign out_data    = odat_q;
    assign out_valid   = ovld_q;
    assign out_last    = olast_q;
    assign frames_held = fh_q;
    assign fill_words  = fill_q;
    assign drop_count  = drop_q;
    assign trunc_count = trunc_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_daq_frame_buffer.sv
// Bench for daq_frame_buffer: expected word stream kept as a queue of whole frames built from
// the framing, admission and truncation rules; the output port is checked against it word by word.
module tb_daq_frame_buffer;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;
    localparam int MAXF  = 16;

    logic          clk = 1'b0;
    logic          hard_rst = 1'b0;
    logic [18:0]   daqp = 19'h40000;
    logic [17:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic [7:0]    frames_held, drop_count, trunc_count;
    logic [AW:0]   fill_words;
    logic          overflow;

    int            pass_cnt = 0;
    int            total_cnt = 0;
    int            rdy_mode = 0;
    int            drop_exp = 0;
    int            trunc_exp = 0;
    logic [18:0]   exp_q[$];
    bit            stall_prev = 1'b0;
    logic [18:0]   prev_word = '0;
    logic [17:0]   fixed_pl[5] = '{18'h0db0a, 18'h0f1c3, 18'h13e55, 18'h18b7e, 18'h1d0aa};

    daq_frame_buffer #(.ADDR_W(AW), .MAX_FRAME(MAXF)) dut (
        .clk(clk), .hard_rst(hard_rst), .daqp(daqp),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frames_held(frames_held), .fill_words(fill_words), .drop_count(drop_count),
        .trunc_count(trunc_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // out_ready pattern: 0 hold low, 1 always high, 2 random, 3 toggle
    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = ~out_ready;
        endcase
    end

    always @(negedge clk) begin
        logic [18:0] w;
        if (!hard_rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'({out_last, out_data}), 32'(prev_word));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_word_queue", 32'(exp_q.size()), 32'd1);
                else begin
                    w = exp_q.pop_front();
                    chk("out_word", 32'({out_last, out_data}), 32'(w));
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input int len, input bit admit, input bit fixed);
        int n;
        logic [17:0] w;
        n = (len < MAXF) ? len : MAXF;
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            w = fixed ? fixed_pl[i] : 18'($urandom);
            daqp = {1'b0, w};
            if (admit && i < n) exp_q.push_back({(i == n - 1), w});
        end
        if (admit && len > MAXF) trunc_exp++;
        if (!admit) drop_exp++;
        @(posedge clk); #1;
        daqp = {1'b1, 18'($urandom)};
    endtask

    function automatic bit fits();
        return (DEPTH - exp_q.size()) >= MAXF;
    endfunction

    task automatic wait_drain(input string tag, input int target);
        for (int c = 0; c < 2000 && exp_q.size() > target; c++) @(posedge clk);
        chk(tag, 32'(exp_q.size() > target), 32'd0);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_idle(input string tag);
        settle(4);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_frames_held"}, 32'(frames_held), 32'd0);
        chk({tag, "_fill"}, 32'(fill_words), 32'd0);
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_frames_held", 32'(frames_held), 32'd0);
        chk("rst_fill", 32'(fill_words), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_trunc", 32'(trunc_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        hard_rst = 1'b1;
        settle(2);

        // single fixed 5-word frame, ready high
        rdy_mode = 1;
        send_frame(5, 1, 1);
        wait_drain("t1_drain", 0);
        check_idle("t1");

        // two 3-word frames held back, then released
        rdy_mode = 0;
        settle(2);
        send_frame(3, 1, 0);
        send_frame(3, 1, 0);
        settle(3);
        chk("t2_frames_held", 32'(frames_held), 32'd2);
        chk("t2_fill", 32'(fill_words), 32'd6);
        chk("t2_valid_stalled", 32'(out_valid), 32'd1);
        rdy_mode = 1;
        wait_drain("t2_drain", 0);
        check_idle("t2");

        // admission: 16 + 10 fit, the following 4-word frame is dropped
        rdy_mode = 0;
        settle(2);
        send_frame(16, fits(), 0);
        send_frame(10, fits(), 0);
        send_frame(4, fits(), 0);
        settle(3);
        chk("t3_drop", 32'(drop_count), 32'(drop_exp));
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_frames_held", 32'(frames_held), 32'd2);
        chk("t3_fill", 32'(fill_words), 32'd26);
        rdy_mode = 1;
        wait_drain("t3_drain", 0);
        check_idle("t3");

        // truncation of a 20-word frame, then an intact frame
        rdy_mode = 0;
        settle(2);
        send_frame(20, fits(), 0);
        send_frame(5, fits(), 0);
        settle(3);
        chk("t4_trunc", 32'(trunc_count), 32'(trunc_exp));
        chk("t4_fill", 32'(fill_words), 32'd21);
        chk("t4_frames_held", 32'(frames_held), 32'd2);
        rdy_mode = 1;
        wait_drain("t4_drain", 0);
        check_idle("t4");

        // ready toggling every cycle
        rdy_mode = 3;
        send_frame(10, 1, 0);
        wait_drain("t5_drain", 0);
        rdy_mode = 1;
        check_idle("t5");

        // random lengths, gaps and backpressure; always room for a worst-case frame
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            wait_drain("rnd_room", DEPTH - MAXF - 1);
            send_frame($urandom_range(1, 20), 1, 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_drain("rnd_drain", 0);
        rdy_mode = 1;
        check_idle("rnd");
        chk("rnd_trunc", 32'(trunc_count), 32'(trunc_exp));
        chk("rnd_drop", 32'(drop_count), 32'(drop_exp));

        // reset during readout and during frame capture
        rdy_mode = 0;
        settle(1);
        send_frame(8, 1, 0);
        settle(2);
        rdy_mode = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            daqp = {1'b0, 18'($urandom)};
        end
        @(posedge clk); #3;
        hard_rst = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_data", 32'(out_data), 32'd0);
        chk("t6_last", 32'(out_last), 32'd0);
        chk("t6_fill", 32'(fill_words), 32'd0);
        chk("t6_frames_held", 32'(frames_held), 32'd0);
        chk("t6_trunc", 32'(trunc_count), 32'd0);
        chk("t6_overflow", 32'(overflow), 32'd0);
        exp_q.delete();
        drop_exp  = 0;
        trunc_exp = 0;
        daqp = {1'b1, 18'd0};
        settle(2);
        hard_rst = 1'b1;
        settle(1);
        send_frame(4, 1, 0);
        wait_drain("t6_drain", 0);
        check_idle("t6_post");
        chk("t6_post_drop", 32'(drop_count), 32'd0);
        chk("t6_post_overflow", 32'(overflow), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
